hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard controller for the ARM PPU five-stage pipeline (IF, ID, EX, MEM, WB). It tracks the destination register of every instruction in flight in EX, MEM and WB through its own shadow slot pipeline. It drives the PC / IF-ID load enables and the CU_mux NOP select for load-use stalls, the IF/ID flush for taken branches, and the operand forwarding selects for the ID/EX PA/PB/PD muxes. It also keeps saturating stall and flush event counters.

## Interface
Parameters:
- CNT_W, 8, width of stall_cnt / flush_cnt
- NO_FWD_REG, 4'd15, register index that is never forwarded (PC read path)

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- Clr  in  1  asynchronous, active-low reset
- ID_Rn  in  4  first source register of the instruction in ID
- ID_Rm  in  4  second source register
- ID_Rd  in  4  store-data source register (STR/STRB)
- ID_use_Rn, ID_use_Rm, ID_use_Rd  in  1 each  source actually read
- ID_Rd_dest  in  4  destination of the instruction in ID
- ID_RF_enable  in  1  instruction in ID writes the register file
- ID_load_instr  in  1  instruction in ID is LDR/LDRB
- ID_B_taken  in  1  B/BL in ID is taken this cycle
- PC_LE  out  1  PC load enable
- IF_ID_LE  out  1  IF/ID load enable
- CU_MUX_E  out  1  1 = CU_mux selects the all-zero NOP bundle
- IF_ID_flush  out  1  clears IF/ID on the next edge
- FWD_A, FWD_B, FWD_D  out  2 each  00 register file, 01 EX result, 10 MEM result, 11 WB result
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Shadow slots EX, MEM, WB each hold {wr, rd[3:0], ld}.
- On each edge: WB<=MEM, MEM<=EX. EX<=bubble (wr=0, ld=0) if stall, else {ID_RF_enable, ID_Rd_dest, ID_load_instr}.
- A slot matches source s when: source used, slot.wr=1, slot.rd==s, and s!=NO_FWD_REG.
- stall = any used source matches the EX slot with EX.ld=1.
- During stall: PC_LE=0, IF_ID_LE=0, CU_MUX_E=1, IF_ID_flush=0. Otherwise PC_LE=1, IF_ID_LE=1, CU_MUX_E=0.
- Forward select per source, first match wins: EX (only if EX.ld=0) -> 01, MEM -> 10, WB -> 11, none -> 00.
- FWD outputs are driven even during stall. They are don't-care there because a NOP is inserted.
- IF_ID_flush = ID_B_taken & ~stall. The branch itself proceeds into EX normally, so BL writes R14 via ID_RF_enable.
- A taken branch coinciding with a stall is not flushed that cycle. It re-presents next cycle and flushes then.
- stall_cnt increments on every edge where stall=1. flush_cnt increments on every edge where IF_ID_flush=1. Both hold at 2^CNT_W-1.

## Timing
- All control and forward outputs are combinational from the ID inputs and registered slots, valid in the same cycle.
- A load-use stall lasts exactly one cycle. The EX slot becomes a bubble, so the next cycle forwards from MEM (10).
- Forwarding distance: dependent instruction 1 cycle behind -> 01, 2 behind -> 10, 3 behind -> 11, 4+ behind -> 00.
- Reset (Clr=0, async): all slots go to bubble and counters go to 0.
- While Clr=0 the outputs are: PC_LE=1, IF_ID_LE=1, CU_MUX_E=1, IF_ID_flush=0, FWD_*=00.
- After Clr rises, the first edge loads the EX slot normally.
- Reset mid-stall clears everything immediately. No stall is pending after release.

## Test plan
- Reset then idle:
  - Clr=0 -> CU_MUX_E=1, PC_LE=1, FWD_*=00, counters 0.
  - Release with no sources used -> CU_MUX_E=0 for 10 cycles, counters stay 0.
- Distance sweep: ADD R1 issued, then SUB reading R1 as Rn on cycles +1, +2, +3, +4 (separate runs) -> FWD_A = 01, 10, 11, 00 respectively.
- Load-use: LDR R2 then ADD with Rm=R2 ->
  - cycle 1: PC_LE=0, IF_ID_LE=0, CU_MUX_E=1;
  - next cycle: FWD_B=10, stall=0;
  - stall_cnt=1.
- Branch:
  - ID_B_taken=1 alone -> IF_ID_flush=1 for that cycle, flush_cnt=1.
  - ID_B_taken=1 during a load-use stall -> IF_ID_flush=0 that cycle, 1 the next.
- Priority and exclusions:
  - EX and MEM both write R3, ID reads R3 via Rd -> FWD_D=01.
  - Source R15 -> 00.
  - Slot with wr=0 and rd=R3 -> 00.
- Saturation and async reset: 300 consecutive load-use pairs -> stall_cnt=255. Pull Clr low between edges mid-stall -> stall_cnt=0 and CU_MUX_E=1 immediately.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Hazard controller for the five-stage ARM PPU pipeline (IF, ID, EX, MEM, WB).
// A private shadow pipeline of three slots (EX, MEM, WB) records, for every
// instruction in flight, whether it writes the register file, which register
// it writes and whether it is a load. From those slots and the instruction
// currently in ID the unit derives:
//   - load-use stalls (freeze PC and IF/ID, inject a NOP through CU_mux),
//   - the IF/ID flush for taken branches,
//   - operand forwarding selects for the ID/EX PA/PB/PD muxes,
//   - saturating stall / flush event counters.
//
// Ports
//   Clk            pipeline clock, rising edge
//   Clr            asynchronous active-low reset
//   ID_Rn/Rm/Rd    source registers of the instruction in ID
//   ID_use_*       source is actually read
//   ID_Rd_dest     destination register of the instruction in ID
//   ID_RF_enable   instruction in ID writes the register file
//   ID_load_instr  instruction in ID is LDR/LDRB
//   ID_B_taken     taken B/BL in ID this cycle
//   PC_LE          PC load enable
//   IF_ID_LE       IF/ID load enable
//   CU_MUX_E       1 = CU_mux selects the all-zero NOP bundle
//   IF_ID_flush    clear IF/ID on the next edge
//   FWD_A/B/D      00 reg file, 01 EX, 10 MEM, 11 WB
//   stall_cnt      saturating count of stall cycles
//   flush_cnt      saturating count of flush cycles
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int unsigned CNT_W      = 8,
    parameter logic [3:0]  NO_FWD_REG = 4'd15
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [3:0]       ID_Rn,
    input  logic [3:0]       ID_Rm,
    input  logic [3:0]       ID_Rd,
    input  logic             ID_use_Rn,
    input  logic             ID_use_Rm,
    input  logic             ID_use_Rd,
    input  logic [3:0]       ID_Rd_dest,
    input  logic             ID_RF_enable,
    input  logic             ID_load_instr,
    input  logic             ID_B_taken,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             CU_MUX_E,
    output logic             IF_ID_flush,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [1:0]       FWD_D,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       wr;
        logic [3:0] rd;
        logic       ld;
    } slot_t;

    localparam slot_t            BUBBLE  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    slot_t ex_slot, mem_slot, wb_slot;
    slot_t id_slot;
    logic  ex_hit;
    logic  stall;

    // A slot supplies a source when that source is read, the slot writes the
    // register file and targets the same register. R15 reads come from the
    // PC path and are never forwarded.
    function automatic logic src_match(input slot_t slot, input logic used,
                                       input logic [3:0] src);
        return used && slot.wr && (slot.rd == src) && (src != NO_FWD_REG);
    endfunction

    // Youngest producer wins. A load still in EX has no data yet, so it is
    // skipped here; that case is a stall and the select is a don't-care.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [3:0] src,
                                           input slot_t ex, input slot_t mem,
                                           input slot_t wb);
        if (src_match(ex, used, src) && !ex.ld)
            return SEL_EX;
        else if (src_match(mem, used, src))
            return SEL_MEM;
        else if (src_match(wb, used, src))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    assign id_slot = '{wr: ID_RF_enable, rd: ID_Rd_dest, ld: ID_load_instr};

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (here by assigning it unconditionally), otherwise a latch is inferred.
    always_comb begin
        ex_hit = src_match(ex_slot, ID_use_Rn, ID_Rn)
               | src_match(ex_slot, ID_use_Rm, ID_Rm)
               | src_match(ex_slot, ID_use_Rd, ID_Rd);
        stall  = ex_hit & ex_slot.ld;
    end

    always_comb begin
        PC_LE       = ~stall;
        IF_ID_LE    = ~stall;
        // NOP select is also held while in reset so nothing leaks into EX.
        CU_MUX_E    = stall | ~Clr;
        // A branch blocked by a stall re-presents next cycle and flushes then.
        IF_ID_flush = ID_B_taken & ~stall & Clr;
        FWD_A       = fwd_sel(ID_use_Rn, ID_Rn, ex_slot, mem_slot, wb_slot);
        FWD_B       = fwd_sel(ID_use_Rm, ID_Rm, ex_slot, mem_slot, wb_slot);
        FWD_D       = fwd_sel(ID_use_Rd, ID_Rd, ex_slot, mem_slot, wb_slot);
    end

    // Shadow slot pipeline. A stalled ID instruction is replaced by a bubble
    // in EX, mirroring the NOP that CU_mux injects into the real pipeline.
    // NOTE: sequential state uses non-blocking assignments so every slot
    // samples its predecessor's pre-edge value, giving a true shift register.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            ex_slot  <= BUBBLE;
            mem_slot <= BUBBLE;
            wb_slot  <= BUBBLE;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= stall ? BUBBLE : id_slot;
        end
    end

    // Saturating event counters.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (IF_ID_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Directed bench for hazard_stall_unit. The stimulus process drives the ID
// inputs shortly after each rising edge and pushes hand-computed expectations
// (value + field mask) into a scoreboard queue. A separate monitor pops and
// compares them on the falling edge, or immediately when the stimulus fires
// sample_ev (used for the asynchronous reset check between edges).
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int CNT_W = 8;

    logic             clk;
    logic             clr;
    logic [3:0]       id_rn, id_rm, id_rd, id_rd_dest;
    logic             id_use_rn, id_use_rm, id_use_rd;
    logic             id_rf_enable, id_load_instr, id_b_taken;
    logic             pc_le, if_id_le, cu_mux_e, if_id_flush;
    logic [1:0]       fwd_a, fwd_b, fwd_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_stall_unit #(.CNT_W(CNT_W), .NO_FWD_REG(4'd15)) dut (
        .Clk          (clk),
        .Clr          (clr),
        .ID_Rn        (id_rn),
        .ID_Rm        (id_rm),
        .ID_Rd        (id_rd),
        .ID_use_Rn    (id_use_rn),
        .ID_use_Rm    (id_use_rm),
        .ID_use_Rd    (id_use_rd),
        .ID_Rd_dest   (id_rd_dest),
        .ID_RF_enable (id_rf_enable),
        .ID_load_instr(id_load_instr),
        .ID_B_taken   (id_b_taken),
        .PC_LE        (pc_le),
        .IF_ID_LE     (if_id_le),
        .CU_MUX_E     (cu_mux_e),
        .IF_ID_flush  (if_id_flush),
        .FWD_A        (fwd_a),
        .FWD_B        (fwd_b),
        .FWD_D        (fwd_d),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {PC_LE, IF_ID_LE, CU_MUX_E, IF_ID_flush,
    //                   FWD_A, FWD_B, FWD_D, stall_cnt, flush_cnt}
    typedef struct {
        string       name;
        logic [25:0] exp;
        logic [25:0] mask;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      sample_ev;
    int        n_checks = 0;
    int        n_errors = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic push(input string name, input logic [25:0] e, input logic [25:0] m);
        sb_entry_t ent;
        ent.name = name;
        ent.exp  = e;
        ent.mask = m;
        sb.push_back(ent);
    endtask

    task automatic expect_ctrl(input string name, input logic pc, input logic ifid,
                               input logic cu, input logic fl);
        push(name, {pc, ifid, cu, fl, 22'b0}, {4'hF, 22'b0});
    endtask

    task automatic expect_fwd(input string name, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] d);
        push(name, {4'b0, a, b, d, 16'b0}, {4'b0, 6'h3F, 16'b0});
    endtask

    task automatic expect_cnt(input string name, input logic [7:0] s, input logic [7:0] f);
        push(name, {10'b0, s, f}, {10'b0, 16'hFFFF});
    endtask

    // ---------------- monitor ----------------
    initial begin
        sb_entry_t   ent;
        logic [25:0] obs;
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0) begin
                ent = sb.pop_front();
                obs = {pc_le, if_id_le, cu_mux_e, if_id_flush,
                       fwd_a, fwd_b, fwd_d, stall_cnt, flush_cnt};
                n_checks++;
                if ((obs & ent.mask) !== (ent.exp & ent.mask)) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h (mask %h) at %0t",
                             ent.name, obs & ent.mask, ent.exp & ent.mask, ent.mask, $time);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input logic [3:0] rn, input logic urn,
                          input logic [3:0] rm, input logic urm,
                          input logic [3:0] rd, input logic urd,
                          input logic [3:0] dest, input logic rf,
                          input logic ld, input logic b);
        id_rn         = rn;
        id_use_rn     = urn;
        id_rm         = rm;
        id_use_rm     = urm;
        id_rd         = rd;
        id_use_rd     = urd;
        id_rd_dest    = dest;
        id_rf_enable  = rf;
        id_load_instr = ld;
        id_b_taken    = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Four NOP cycles push every earlier producer out of the shadow slots.
    task automatic drain_pipe();
        repeat (4) begin
            next_cycle();
            nop();
        end
    endtask

    // LDR R2 (no sources read)
    task automatic ldr_r2();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
    endtask

    // ADD R6, R0, R2 (reads R2 through Rm), optionally a taken branch
    task automatic add_use_r2(input logic b);
        set_id(4'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, b);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr = 1'b0;
        nop();

        // Reset held: sources read but every slot is a bubble.
        next_cycle();
        set_id(4'd1, 1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        expect_ctrl("rst_ctrl", 1'b1, 1'b1, 1'b1, 1'b0);
        expect_fwd ("rst_fwd", 2'b00, 2'b00, 2'b00);
        expect_cnt ("rst_cnt", 8'd0, 8'd0);

        // Release and idle with nothing read.
        next_cycle();
        clr = 1'b1;
        nop();
        for (int i = 0; i < 10; i++) begin
            expect_ctrl("idle_ctrl", 1'b1, 1'b1, 1'b0, 1'b0);
            expect_cnt ("idle_cnt", 8'd0, 8'd0);
            if (i < 9) next_cycle();
        end

        // Distance sweep: ADD R1 then SUB R5, R1 after d cycles.
        for (int d = 1; d <= 4; d++) begin
            logic [1:0] want;
            want = (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : (d == 3) ? 2'b11 : 2'b00;
            drain_pipe();
            next_cycle();
            set_id(4'd3, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
            for (int g = 1; g < d; g++) begin
                next_cycle();
                nop();
            end
            next_cycle();
            set_id(4'd1, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
            expect_fwd ($sformatf("dist%0d_fwd", d), want, 2'b00, 2'b00);
            expect_ctrl($sformatf("dist%0d_ctrl", d), 1'b1, 1'b1, 1'b0, 1'b0);
        end

        // Load-use: LDR R2, ADD ..., R2
        drain_pipe();
        next_cycle();
        ldr_r2();
        next_cycle();
        add_use_r2(1'b0);
        expect_ctrl("lu_stall_ctrl", 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        add_use_r2(1'b0);
        expect_ctrl("lu_after_ctrl", 1'b1, 1'b1, 1'b0, 1'b0);
        expect_fwd ("lu_after_fwd", 2'b00, 2'b10, 2'b00);
        expect_cnt ("lu_cnt", 8'd1, 8'd0);

        // Taken branch alone (BL writes R14).
        drain_pipe();
        next_cycle();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0, 1'b1);
        expect_ctrl("br_ctrl", 1'b1, 1'b1, 1'b0, 1'b1);
        expect_cnt ("br_cnt_before", 8'd1, 8'd0);
        next_cycle();
        nop();
        expect_cnt ("br_cnt_after", 8'd1, 8'd1);

        // Taken branch during a load-use stall: flush deferred one cycle.
        drain_pipe();
        next_cycle();
        ldr_r2();
        next_cycle();
        add_use_r2(1'b1);
        expect_ctrl("brst_stall_ctrl", 1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        add_use_r2(1'b1);
        expect_ctrl("brst_flush_ctrl", 1'b1, 1'b1, 1'b0, 1'b1);
        expect_cnt ("brst_cnt_mid", 8'd2, 8'd1);
        next_cycle();
        nop();
        expect_cnt ("brst_cnt_after", 8'd2, 8'd2);

        // Priority: EX and MEM both write R3, ID reads R3 via Rd and Rn.
        drain_pipe();
        next_cycle();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_id(4'd3, 1'b1, 4'd8, 1'b1, 4'd3, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        expect_fwd("prio_fwd", 2'b01, 2'b00, 2'b01);

        // R15 is never forwarded even when EX writes it.
        drain_pipe();
        next_cycle();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0);
        next_cycle();
        set_id(4'd15, 1'b1, 4'd0, 1'b0, 4'd15, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        expect_fwd("r15_fwd", 2'b00, 2'b00, 2'b00);

        // Slot with wr=0 and rd=R3 does not forward.
        drain_pipe();
        next_cycle();
        set_id(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_id(4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        expect_fwd("nowr_fwd", 2'b00, 2'b00, 2'b00);

        // Saturation: 300 more load-use pairs on top of 2 recorded stalls.
        drain_pipe();
        for (int k = 0; k < 300; k++) begin
            next_cycle();
            ldr_r2();
            next_cycle();
            add_use_r2(1'b0);
            next_cycle();
            add_use_r2(1'b0);
        end
        expect_cnt("sat_cnt", 8'd255, 8'd2);

        // Async reset mid-stall, asserted between edges.
        drain_pipe();
        next_cycle();
        ldr_r2();
        next_cycle();
        add_use_r2(1'b0);
        expect_ctrl("rst_mid_stall_ctrl", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        clr = 1'b0;
        #1;
        expect_ctrl("async_rst_ctrl", 1'b1, 1'b1, 1'b1, 1'b0);
        expect_cnt ("async_rst_cnt", 8'd0, 8'd0);
        expect_fwd ("async_rst_fwd", 2'b00, 2'b00, 2'b00);
        -> sample_ev;
        next_cycle();
        clr = 1'b1;
        expect_ctrl("post_rst_ctrl", 1'b1, 1'b1, 1'b0, 1'b0);
        expect_fwd ("post_rst_fwd", 2'b00, 2'b00, 2'b00);
        expect_cnt ("post_rst_cnt", 8'd0, 8'd0);

        // Bounded wait for the monitor to consume everything.
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
